// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//   Program counter and next-PC resolution for the single-cycle MIPS core.
//   The PC addresses the instruction ROM (as a byte offset from TEXT_BASE).
//   The returned instruction word is decoded in the same cycle to pick the
//   next PC. The decoded cases are beq/bne/j/jal/jr and the exit syscall.
//   Any out-of-range or misaligned next PC freezes the core with a sticky fault.
//
// Ports
//   clk          in   core clock, rising edge
//   reset        in   synchronous, active-high reset
//   stall        in   hold PC this cycle (syscall not evaluated)
//   instruction  in   ROM word for the current rom_address
//   rs_value     in   register value of instruction[25:21]
//   rt_value     in   register value of instruction[20:16]
//   v0_value     in   current $v0, for syscall decode
//   rom_address  out  pc - TEXT_BASE (word aligned byte offset)
//   pc           out  current architectural PC
//   pc_plus4     out  pc + 4, also the jal link value
//   halted       out  sticky: exit syscall or fetch fault
//   fetch_fault  out  sticky: next PC out of range or jr misaligned
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [31:0] ROM_BYTES = 32'd16384,
  parameter logic [31:0] EXIT_CODE = 32'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic [31:0] v0_value,
  output logic [31:0] rom_address,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fetch_fault
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic signed [31:0] br_off;
  logic [31:0]        br_tgt;
  logic [31:0]        jmp_tgt;
  logic [31:0]        cand_pc;
  logic [31:0]        cand_off;
  logic               is_exit;
  logic               jr_misalign;
  logic               cand_fault;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  assign pc_plus4    = pc_q + 32'd4;
  assign rom_address = pc_q - TEXT_BASE;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fetch_fault = fault_q;

  // Sign-extend imm16 before the shift so backward branches wrap correctly.
  assign br_off  = {{14{instruction[15]}}, instruction[15:0], 2'b00};
  assign br_tgt  = pc_plus4 + br_off;
  assign jmp_tgt = {pc_plus4[31:28], instruction[25:0], 2'b00};

  // Candidate next PC, ignoring halt/stall/fault.
  always_comb begin
    cand_pc     = pc_plus4;
    is_exit     = 1'b0;
    jr_misalign = 1'b0;
    unique case (opcode)
      OP_BEQ:  cand_pc = (rs_value == rt_value) ? br_tgt : pc_plus4;
      OP_BNE:  cand_pc = (rs_value != rt_value) ? br_tgt : pc_plus4;
      OP_J,
      OP_JAL:  cand_pc = jmp_tgt;
      OP_SPECIAL: begin
        if (funct == FN_JR) begin
          cand_pc     = rs_value;
          jr_misalign = (rs_value[1:0] != 2'b00);
        end else if (funct == FN_SYSCALL && v0_value == EXIT_CODE) begin
          is_exit = 1'b1;
        end
      end
      default: cand_pc = pc_plus4;
    endcase
  end

  // Unsigned offset compare covers both ends of the window; values below
  // TEXT_BASE wrap to large offsets. The ROM end itself is out of range.
  assign cand_off   = cand_pc - TEXT_BASE;
  assign cand_fault = jr_misalign || (cand_off >= ROM_BYTES);

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    if (halted_q || stall) begin
      pc_d = pc_q;
    end else if (is_exit) begin
      halted_d = 1'b1;
    end else if (cand_fault) begin
      halted_d = 1'b1;
      fault_d  = 1'b1;
    end else begin
      pc_d = cand_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= TEXT_BASE;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic [31:0] v0_value;
  logic [31:0] rom_address;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .instruction (instruction),
    .rs_value    (rs_value),
    .rt_value    (rt_value),
    .v0_value    (v0_value),
    .rom_address (rom_address),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .halted      (halted),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Jump to a target PC using a j instruction.
  task automatic goto_pc(input logic [31:0] tgt);
    instruction = {6'h02, tgt[27:2]};
    step();
    chk("goto", pc, tgt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; instruction = 32'h0;
    rs_value = 32'h0; rt_value = 32'h0; v0_value = 32'h0;
    step();
    step();
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_rom", rom_address, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h0000_3004);
    chk("rst_halt", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    reset = 1'b0;

    // Ten sequential nops
    instruction = 32'h0000_0000;
    repeat (10) step();
    chk("seq10", pc, 32'h0000_3028);

    // j
    goto_pc(32'h0000_3004);
    instruction = 32'h0800_0c05;
    step();
    chk("j_pc", pc, 32'h0000_3014);
    chk("j_rom", rom_address, 32'h0000_0014);

    // beq taken / not taken
    goto_pc(32'h0000_3064);
    instruction = 32'h1220_0001; rs_value = 32'd0; rt_value = 32'd0;
    step();
    chk("beq_taken", pc, 32'h0000_306C);
    goto_pc(32'h0000_3064);
    instruction = 32'h1220_0001; rs_value = 32'd1; rt_value = 32'd0;
    step();
    chk("beq_nt", pc, 32'h0000_3068);

    // bne backward taken / not taken
    goto_pc(32'h0000_3168);
    instruction = 32'h1500_fff9; rs_value = 32'd8; rt_value = 32'd1;
    step();
    chk("bne_taken", pc, 32'h0000_3150);
    goto_pc(32'h0000_3168);
    instruction = 32'h1500_fff9; rs_value = 32'd1; rt_value = 32'd1;
    step();
    chk("bne_nt", pc, 32'h0000_316C);

    // jal then jr
    goto_pc(32'h0000_3044);
    instruction = 32'h0c00_0cb8;
    chk("jal_link", pc_plus4, 32'h0000_3048);
    step();
    chk("jal_pc", pc, 32'h0000_32E0);
    instruction = 32'h03e0_0008; rs_value = 32'h0000_3048;
    step();
    chk("jr_pc", pc, 32'h0000_3048);
    rs_value = 32'h0000_304A;
    step();
    chk("jr_mis_pc", pc, 32'h0000_3048);
    chk("jr_mis_flt", {31'b0, fetch_fault}, 32'd1);
    chk("jr_mis_hlt", {31'b0, halted}, 32'd1);
    step();
    chk("flt_frozen", pc, 32'h0000_3048);

    do_reset();
    chk("rst2_pc", pc, 32'h0000_3000);
    chk("rst2_flt", {31'b0, fetch_fault}, 32'd0);

    // syscall with non-exit code, then exit
    instruction = 32'h0000_000c; v0_value = 32'd34;
    step();
    chk("sys34", pc, 32'h0000_3004);
    chk("sys34_hlt", {31'b0, halted}, 32'd0);
    v0_value = 32'd10;
    step();
    chk("exit_pc", pc, 32'h0000_3004);
    chk("exit_hlt", {31'b0, halted}, 32'd1);
    chk("exit_flt", {31'b0, fetch_fault}, 32'd0);
    instruction = 32'h0800_0c05;
    for (int i = 0; i < 20; i++) begin
      stall = i[0];
      step();
      chk("halt_frz", pc, 32'h0000_3004);
    end
    chk("halt_stick", {31'b0, halted}, 32'd1);
    stall = 1'b0;
    do_reset();
    chk("rst3_pc", pc, 32'h0000_3000);
    chk("rst3_hlt", {31'b0, halted}, 32'd0);

    // Stall holds PC, then releases
    instruction = 32'h0800_0c05; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", pc, 32'h0000_3000);
    end
    stall = 1'b0;
    step();
    chk("stall_rel", pc, 32'h0000_3014);

    // Exit syscall ignored while stalled
    instruction = 32'h0000_000c; v0_value = 32'd10; stall = 1'b1;
    step();
    chk("stall_sys_hlt", {31'b0, halted}, 32'd0);
    chk("stall_sys_pc", pc, 32'h0000_3014);
    stall = 1'b0;

    // Reset mid-branch discards the target
    instruction = 32'h0800_0c19; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_branch", pc, 32'h0000_3000);

    // Last ROM word: pc+4 equals ROM end and faults
    goto_pc(32'h0000_6FFC);
    instruction = 32'h0000_0000;
    step();
    chk("end_pc", pc, 32'h0000_6FFC);
    chk("end_flt", {31'b0, fetch_fault}, 32'd1);
    do_reset();

    // Jump below TEXT_BASE faults
    instruction = 32'h0800_0000;
    step();
    chk("low_pc", pc, 32'h0000_3000);
    chk("low_flt", {31'b0, fetch_fault}, 32'd1);
    chk("low_hlt", {31'b0, halted}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
